// File: rtl/rp_gpio_pkg.sv
// Shared types for the rp_gpio controller: FSM state encoding and the
// turnaround counter width.
package rp_gpio_pkg;

  localparam int TURN_CNT_W = 8;

  typedef logic [TURN_CNT_W-1:0] turn_cnt_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_TURN = 1'b1
  } gpio_state_e;

endpackage

// File: rtl/rp_gpio_edge_detect.sv
// Per-pin rise/fall pulse generator for pins that stay inputs across two
// consecutive cycles. Pulses are registered: they appear one cycle after the edge.
module rp_gpio_edge_detect #(
  parameter int N_PINS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_PINS-1:0] i_val,
  input  logic [N_PINS-1:0] i_dir,
  output logic [N_PINS-1:0] o_rise,
  output logic [N_PINS-1:0] o_fall
);

  // Low for the first cycle after reset so the freshly loaded history is not compared.
  logic r_primed;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_primed <= 1'b0;
    end else begin
      r_primed <= 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_PINS; gi++) begin : g_pin
      logic r_prev_val;
      logic r_prev_dir;
      logic r_rise;
      logic r_fall;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_prev_val <= i_val[gi];
          r_prev_dir <= 1'b1;
          r_rise     <= 1'b0;
          r_fall     <= 1'b0;
        end else begin
          r_prev_val <= i_val[gi];
          r_prev_dir <= i_dir[gi];
          r_rise     <= r_primed & r_prev_dir & i_dir[gi] & ~r_prev_val &  i_val[gi];
          r_fall     <= r_primed & r_prev_dir & i_dir[gi] &  r_prev_val & ~i_val[gi];
        end
      end

      assign o_rise[gi] = r_rise;
      assign o_fall[gi] = r_fall;
    end
  endgenerate

endmodule

// File: rtl/rp_gpio_ctrl.sv
// GPIO direction/level controller with input->output turnaround delay.
// Edge detection is built only when RP_GPIO_EDGE_DETECT_EN is defined.
module rp_gpio_ctrl
  import rp_gpio_pkg::*;
#(
  parameter int N_PINS      = 8,
  parameter int TURN_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [N_PINS-1:0] cfg_mask,
  input  logic [N_PINS-1:0] cfg_dir,
  input  logic [N_PINS-1:0] cfg_out,
  input  logic [N_PINS-1:0] val_in_clocked,
  output logic [N_PINS-1:0] val_out,
  output logic [N_PINS-1:0] direction,
  output logic [N_PINS-1:0] rise,
  output logic [N_PINS-1:0] fall
);

  gpio_state_e       r_state;
  turn_cnt_t         r_cnt;
  logic [N_PINS-1:0] r_dir;
  logic [N_PINS-1:0] r_val_out;
  logic [N_PINS-1:0] r_pending;

  logic              w_accept;
  logic              w_turn_done;
  logic [N_PINS-1:0] w_pending_new;
  logic [N_PINS-1:0] w_to_input;

  assign cfg_ready     = (r_state == ST_IDLE);
  assign w_accept      = cfg_valid & cfg_ready;
  // Pending = currently input and asked to drive; everything else may apply at once.
  assign w_pending_new = cfg_mask & r_dir & ~cfg_dir;
  assign w_to_input    = cfg_mask & cfg_dir;
  assign w_turn_done   = (r_state == ST_TURN) && (r_cnt == turn_cnt_t'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_dir     <= '1;
      r_val_out <= '0;
      r_pending <= '0;
    end else if (w_accept) begin
      r_val_out <= (r_val_out & ~cfg_mask) | (cfg_out & cfg_mask);
      r_dir     <= r_dir | w_to_input;
      if (|w_pending_new) begin
        r_state   <= ST_TURN;
        r_cnt     <= turn_cnt_t'(TURN_CYCLES);
        r_pending <= w_pending_new;
      end
    end else if (r_state == ST_TURN) begin
      // Counter loaded with TURN_CYCLES at accept; release when it reads 1.
      if (w_turn_done) begin
        r_dir     <= r_dir & ~r_pending;
        r_pending <= '0;
        r_state   <= ST_IDLE;
      end else begin
        r_cnt <= r_cnt - turn_cnt_t'(1);
      end
    end
  end

  assign val_out   = r_val_out;
  assign direction = r_dir;

`ifdef RP_GPIO_EDGE_DETECT_EN
  rp_gpio_edge_detect #(
    .N_PINS (N_PINS)
  ) u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_val  (val_in_clocked),
    .i_dir  (r_dir),
    .o_rise (rise),
    .o_fall (fall)
  );
`else
  logic w_unused_val_in;
  assign w_unused_val_in = ^val_in_clocked;
  assign rise = '0;
  assign fall = '0;
`endif

endmodule
